// File: rtl/corr_acc_dump_ctrl.sv
// -----------------------------------------------------------------------------
// corr_acc_dump_ctrl
//
// Control and capture stage sitting directly behind the correlator
// accumulators (aa, bb, ab_re, ab_im).
//   * Counts valid DFT samples against a software-set integration length and
//     raises acc_done on the last sample of each integration.
//   * Captures each accumulator dump and writes the four results, at one
//     shared address, into four result BRAM write ports (1-cycle latency).
//   * Capture is one-shot (stop when the buffer is full) or continuous (wrap).
//     Dumps arriving after a one-shot capture has filled are counted.
//
// Optional feature macro: DUMP_TIMESTAMP_EN
//   Adds dump_seq (free-running dump sequence number) and bram_seq (copy of
//   dump_seq registered alongside bram_we, for a fifth BRAM).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cnt_rst             synchronous clear of the sample counter (active-high)
//   acc_len             samples per integration (0 behaves as 1)
//   samp_valid          DFT output valid
//   acc_done            last sample of the integration (combinational)
//   acc_valid, acc_*    aligned accumulator dump
//   arm                 single-cycle pulse that (re)starts capture at slot 0
//   continuous          1 = wrap and keep writing, 0 = stop when full
//   bram_we/addr/*      shared write port of the result BRAMs
//   busy                capture in progress
//   buf_full            one-shot capture complete
//   drop_count          dumps discarded after a one-shot capture (saturating)
// -----------------------------------------------------------------------------
module corr_acc_dump_ctrl #(
    parameter int DIN_WIDTH  = 32,
    parameter int BRAM_DEPTH = 128,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_rst,
    input  logic [31:0]           acc_len,
    input  logic                  samp_valid,
    output logic                  acc_done,
    input  logic                  acc_valid,
    input  logic [DIN_WIDTH-1:0]  acc_aa,
    input  logic [DIN_WIDTH-1:0]  acc_bb,
    input  logic [DIN_WIDTH-1:0]  acc_ab_re,
    input  logic [DIN_WIDTH-1:0]  acc_ab_im,
    input  logic                  arm,
    input  logic                  continuous,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DIN_WIDTH-1:0]  bram_aa,
    output logic [DIN_WIDTH-1:0]  bram_bb,
    output logic [DIN_WIDTH-1:0]  bram_ab_re,
    output logic [DIN_WIDTH-1:0]  bram_ab_im,
    output logic                  busy,
    output logic                  buf_full,
    output logic [DROP_WIDTH-1:0] drop_count
`ifdef DUMP_TIMESTAMP_EN
    ,
    output logic [31:0]           dump_seq,
    output logic [31:0]           bram_seq
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] waddr, waddr_n;
    logic                  capture;
    logic                  buf_full_n;
    logic [DROP_WIDTH-1:0] drop_n;

    logic [31:0]           cnt;
    logic [31:0]           len_reg;
    logic [31:0]           len_load;

    // Output register stage (one cycle behind the accepted dump)
    logic                  we_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DIN_WIDTH-1:0]  aa_p1, bb_p1, ab_re_p1, ab_im_p1;

    // ---------------- sample counter ----------------
    // A zero length would never terminate; treat it as one sample.
    assign len_load = (acc_len == 32'd0) ? 32'd1 : acc_len;

    // cnt_rst suppresses the strobe; reset gating keeps every output low in reset.
    assign acc_done = rst && samp_valid && !cnt_rst && (cnt == len_reg - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= 32'd0;
            len_reg <= len_load;
        end else if (cnt_rst || acc_done) begin
            cnt     <= 32'd0;
            len_reg <= len_load;
        end else if (samp_valid) begin
            cnt     <= cnt + 32'd1;
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        state_n    = state;
        waddr_n    = waddr;
        capture    = 1'b0;
        buf_full_n = buf_full;
        drop_n     = drop_count;
        // arm has priority over a coincident dump, which is discarded uncounted
        if (arm) begin
            state_n    = FILL;
            waddr_n    = '0;
            buf_full_n = 1'b0;
            drop_n     = '0;
        end else begin
            case (state)
                FILL: begin
                    if (acc_valid) begin
                        capture = 1'b1;
                        waddr_n = waddr + 1'b1;  // natural wrap at BRAM_DEPTH
                        if (waddr == {ADDR_WIDTH{1'b1}} && !continuous) begin
                            state_n    = DONE;
                            buf_full_n = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_valid && drop_count != {DROP_WIDTH{1'b1}})
                        drop_n = drop_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            waddr      <= '0;
            buf_full   <= 1'b0;
            drop_count <= '0;
            we_p1      <= 1'b0;
            addr_p1    <= '0;
            aa_p1      <= '0;
            bb_p1      <= '0;
            ab_re_p1   <= '0;
            ab_im_p1   <= '0;
        end else begin
            state      <= state_n;
            waddr      <= waddr_n;
            buf_full   <= buf_full_n;
            drop_count <= drop_n;
            we_p1      <= capture;
            // data holds its last value between writes
            if (capture) begin
                addr_p1  <= waddr;
                aa_p1    <= acc_aa;
                bb_p1    <= acc_bb;
                ab_re_p1 <= acc_ab_re;
                ab_im_p1 <= acc_ab_im;
            end
        end
    end

    assign bram_we    = we_p1;
    assign bram_addr  = addr_p1;
    assign bram_aa    = aa_p1;
    assign bram_bb    = bb_p1;
    assign bram_ab_re = ab_re_p1;
    assign bram_ab_im = ab_im_p1;
    assign busy       = (state == FILL);

`ifdef DUMP_TIMESTAMP_EN
    // Counts every dump regardless of state, so gaps in bram_seq reveal drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dump_seq <= 32'd0;
            bram_seq <= 32'd0;
        end else begin
            if (acc_valid)
                dump_seq <= dump_seq + 32'd1;
            if (capture)
                bram_seq <= dump_seq;
        end
    end
`endif

endmodule

// File: tb/tb_corr_acc_dump_ctrl.sv
module tb_corr_acc_dump_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DRW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_rst;
    logic [31:0]   acc_len;
    logic          samp_valid;
    logic          acc_done;
    logic          acc_valid;
    logic [DW-1:0] acc_aa, acc_bb, acc_ab_re, acc_ab_im;
    logic          arm;
    logic          continuous;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_aa, bram_bb, bram_ab_re, bram_ab_im;
    logic          busy;
    logic          buf_full;
    logic [DRW-1:0] drop_count;
`ifdef DUMP_TIMESTAMP_EN
    logic [31:0]   dump_seq, bram_seq;
`endif

    corr_acc_dump_ctrl #(
        .DIN_WIDTH (DW),
        .BRAM_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .DROP_WIDTH(DRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_rst   (cnt_rst),
        .acc_len   (acc_len),
        .samp_valid(samp_valid),
        .acc_done  (acc_done),
        .acc_valid (acc_valid),
        .acc_aa    (acc_aa),
        .acc_bb    (acc_bb),
        .acc_ab_re (acc_ab_re),
        .acc_ab_im (acc_ab_im),
        .arm       (arm),
        .continuous(continuous),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_aa   (bram_aa),
        .bram_bb   (bram_bb),
        .bram_ab_re(bram_ab_re),
        .bram_ab_im(bram_ab_im),
        .busy      (busy),
        .buf_full  (buf_full),
        .drop_count(drop_count)
`ifdef DUMP_TIMESTAMP_EN
        ,
        .dump_seq  (dump_seq),
        .bram_seq  (bram_seq)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] aa, bb, re, im;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every bram_we must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (bram_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d aa=%0h at cyc %0d, required no write",
                         bram_addr, bram_aa, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (32'(bram_addr) !== e.addr || bram_aa !== e.aa || bram_bb !== e.bb ||
                    bram_ab_re !== e.re || bram_ab_im !== e.im || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d aa=%0h bb=%0h re=%0h im=%0h cyc=%0d, required addr=%0d aa=%0h bb=%0h re=%0h im=%0h cyc=%0d",
                             bram_addr, bram_aa, bram_bb, bram_ab_re, bram_ab_im, cyc,
                             e.addr, e.aa, e.bb, e.re, e.im, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One samp_valid cycle; acc_done is checked combinationally in that cycle.
    task automatic samp(input logic exp_done, input string name);
        samp_valid = 1'b1;
        #1;
        chk(name, 32'(acc_done), 32'(exp_done));
        tick();
        samp_valid = 1'b0;
    endtask

    // One acc_valid cycle; pushes the expected write when it should be stored.
    task automatic dump(input logic [31:0] a, input logic exp_wr, input logic [31:0] addr);
        exp_t e;
        acc_valid = 1'b1;
        acc_aa    = a;
        acc_bb    = 32'h0000_1000 + a;
        acc_ab_re = 32'hFFFF_FF00 - a;
        acc_ab_im = 32'h8000_0000 | a;
        if (exp_wr) begin
            e.addr = addr;
            e.aa   = a;
            e.bb   = 32'h0000_1000 + a;
            e.re   = 32'hFFFF_FF00 - a;
            e.im   = 32'h8000_0000 | a;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cnt_rst = 1'b0; acc_len = 32'd4; samp_valid = 1'b0;
        acc_valid = 1'b0; acc_aa = '0; acc_bb = '0; acc_ab_re = '0; acc_ab_im = '0;
        arm = 1'b0; continuous = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_we",       32'(bram_we), 32'd0);
        chk("rst_addr",     32'(bram_addr), 32'd0);
        chk("rst_aa",       bram_aa, 32'd0);
        chk("rst_im",       bram_ab_im, 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_buf_full", 32'(buf_full), 32'd0);
        chk("rst_drop",     32'(drop_count), 32'd0);
        chk("rst_acc_done", 32'(acc_done), 32'd0);
        rst = 1'b1;
        tick();

        // Integration length 4: acc_done on samples 4, 8, 12
        for (int i = 1; i <= 12; i++)
            samp((i % 4) == 0, $sformatf("len4_s%0d", i));

        // Length 0 behaves as 1; a new length takes effect at the next boundary
        acc_len = 32'd0; cnt_rst = 1'b1; tick(); cnt_rst = 1'b0;
        samp(1'b1, "len0_s1");
        samp(1'b1, "len0_s2");
        acc_len = 32'd5;
        samp(1'b1, "len0_s3");
        for (int i = 1; i <= 5; i++)
            samp(i == 5, $sformatf("len5_s%0d", i));
        for (int i = 1; i <= 4; i++)
            samp(1'b0, $sformatf("len5b_s%0d", i));
        // cnt_rst on what would be the last sample suppresses acc_done
        acc_len = 32'd1; cnt_rst = 1'b1;
        samp(1'b0, "cnt_rst_no_done");
        cnt_rst = 1'b0;
        samp(1'b1, "len1_after_clr");

        // IDLE ignores dumps
        dump(32'h7, 1'b0, 0);
        tick();
        chk("idle_drop", 32'(drop_count), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // One-shot: 6 dumps into 4 slots
        continuous = 1'b0;
        pulse_arm();
        chk("arm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            dump(32'(10 + i), i < 4, 32'(i));
            if (i < 3) begin
                chk($sformatf("os_busy%0d", i), 32'(busy), 32'd1);
                chk($sformatf("os_full%0d", i), 32'(buf_full), 32'd0);
            end else if (i == 3) begin
                chk("os_last_we",   32'(bram_we), 32'd1);
                chk("os_last_full", 32'(buf_full), 32'd1);
                chk("os_last_busy", 32'(busy), 32'd0);
            end
        end
        tick();
        chk("os_we_idle", 32'(bram_we), 32'd0);
        chk("os_aa_hold", bram_aa, 32'd13);
        chk("os_drop2",   32'(drop_count), 32'd2);

        // Drop counter saturates at all-ones
        for (int i = 0; i < 7; i++) dump(32'(20 + i), 1'b0, 0);
        chk("drop_sat", 32'(drop_count), 32'd7);

        // arm together with a dump in DONE: no write, counters cleared
        arm = 1'b1;
        dump(32'h40, 1'b0, 0);
        arm = 1'b0;
        chk("armdone_drop", 32'(drop_count), 32'd0);
        chk("armdone_full", 32'(buf_full), 32'd0);
        chk("armdone_busy", 32'(busy), 32'd1);
        chk("armdone_we",   32'(bram_we), 32'd0);
        dump(32'h55, 1'b1, 32'd0);

        // Continuous: restart and wrap 0,1,2,3,0,1
        continuous = 1'b1;
        pulse_arm();
        for (int i = 0; i < 6; i++) begin
            dump(32'(32'h60 + i), 1'b1, 32'(i % 4));
            chk($sformatf("cont_full%0d", i), 32'(buf_full), 32'd0);
            chk($sformatf("cont_busy%0d", i), 32'(busy), 32'd1);
        end

        // Reset mid-write at waddr 2
        continuous = 1'b0;
        pulse_arm();
        dump(32'h70, 1'b1, 32'd0);
        dump(32'h71, 1'b1, 32'd1);
        rst = 1'b0;
        dump(32'h72, 1'b0, 0);
        rst = 1'b1;
        chk("mid_rst_we",   32'(bram_we), 32'd0);
        chk("mid_rst_addr", 32'(bram_addr), 32'd0);
        chk("mid_rst_aa",   bram_aa, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        dump(32'h73, 1'b0, 0);
        chk("post_rst_we",   32'(bram_we), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        pulse_arm();
        dump(32'h74, 1'b1, 32'd0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
